alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL provide parameter: W, 4, operand width in bits (legal range 2..8).
REQ-002 SHALL use one clock and a synchronous, active-low reset: all state updates on rising CLK; RST_N low at a rising edge resets.
REQ-003 CLK  input  1  system clock.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 req0_A, req0_B / req1_A, req1_B  input  W  unsigned operands.
REQ-008 req0_op / req1_op  input  4  opcode: 4'b0001 add, 4'b0010 sub, 4'b0100 mul; other values illegal.
REQ-009 out  output  16  registered result.
REQ-010 out_valid  output  1  one-cycle pulse marking a new result.
REQ-011 out_id  output  1  requester that issued the result.
REQ-012 err  output  1  high with out_valid when the opcode was illegal.

Function
REQ-013 SHALL share one ALU datapath between two requesters through an FSM with states IDLE, ALU, MUL and RESP.
REQ-014 In IDLE, SHALL assert req_ready combinationally only to the arbitration winner among asserted valids; in all other states both readies SHALL be 0.
REQ-015 Transfer occurs when valid and ready are both high at a rising edge; operands, opcode and id SHALL be captured at that edge.
REQ-016 Transfer edge: IDLE->ALU for add, sub or illegal opcode; IDLE->MUL for mul.
REQ-017 ALU: one cycle; computes add as A+B, or sub as A-B modulo 2^16, with zero-extended operands (3-5 = 16'hFFFE); illegal opcode gives out=0, err=1; then ALU->RESP.
REQ-018 MUL: W-cycle shift-add multiply, one partial product per cycle; exact unsigned product, zero-extended to 16 bits; then MUL->RESP.
REQ-019 RESP: exactly one cycle; out_valid=1 with out, out_id and err updated; then RESP->IDLE.
REQ-020 Latency from transfer edge to out_valid high SHALL be 2 cycles for add, sub and illegal opcodes, and W+1 cycles for mul.
REQ-021 Throughput: the next transfer occurs no earlier than the cycle after RESP.
REQ-022 out, out_id and err SHALL hold their values between results; err SHALL be 0 for legal opcodes.
REQ-023 Requester inputs SHALL be ignored outside IDLE; a requester holding valid SHALL keep it asserted until it sees ready.
REQ-024 Tie rule (both valid in IDLE) SHALL follow REQ-030/031; a single valid requester always wins.

Reset
REQ-025 With RST_N low at an edge: state=IDLE; out=0; out_valid=0; out_id=0; err=0; last-served=1; multiply accumulator cleared.
REQ-026 Reset mid-operation (ALU, MUL or RESP) SHALL abort the operation with no out_valid pulse for it.
REQ-027 While RST_N is low, req0_ready and req1_ready SHALL be 0.
REQ-028 After reset release, the first tie SHALL be granted to requester 0.

Configuration
REQ-029 Macro ALU_ARB_RR_EN selects the tie-breaking policy.
REQ-030 Defined: round-robin; on a tie, the requester not served last wins; last-served updates at every transfer.
REQ-031 Undefined: fixed priority; requester 0 always wins ties; last-served is unused.

Verification
REQ-032 req0 add A=9, B=7 -> req0_ready at transfer; out_valid 2 cycles later; out=16'h0010, out_id=0, err=0.
REQ-033 req1 sub A=3, B=5 -> out=16'hFFFE, out_id=1; req1 mul A=15, B=15 (W=4) -> out=16'h00E1, out_valid 5 cycles after transfer.
REQ-034 Both valid continuously, four ops each, with ALU_ARB_RR_EN -> grants 0,1,0,1,...; without the macro -> all req0 ops complete before any req1 op.
REQ-035 req0 op=4'b1000 -> out=0, err=1, out_valid 2 cycles after transfer; the following legal op -> err=0.
REQ-036 RST_N low during cycle 2 of MUL -> no out_valid; all outputs at reset values; the next tie is granted to req0.
REQ-037 Both valids held high -> neither ready is high during ALU, MUL or RESP; exactly one out_valid per transfer.

Source files
------------

// File: rtl/alu_arb_if.sv
// alu_arb_if: two requester ports and the shared result bus.
interface alu_arb_if #(
  parameter int W = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_A;
  logic [W-1:0] req0_B;
  logic [3:0]   req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_A;
  logic [W-1:0] req1_B;
  logic [3:0]   req1_op;
  logic [15:0]  out;
  logic         out_valid;
  logic         out_id;
  logic         err;

  modport master (
    output req0_valid, req0_A, req0_B, req0_op,
    output req1_valid, req1_A, req1_B, req1_op,
    input  req0_ready, req1_ready,
    input  out, out_valid, out_id, err
  );

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_op,
    input  req1_valid, req1_A, req1_B, req1_op,
    output req0_ready, req1_ready,
    output out, out_valid, out_id, err
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one add/sub/shift-add-mul datapath.
// ALU_ARB_RR_EN: round-robin ties (default: requester 0 wins ties).
module alu_arb #(
  parameter int W = 4
) (
  input logic     CLK,
  input logic     RST_N,
  alu_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ALU, MUL, RESP
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;

  state_e       state_q, state_d;
  logic [15:0]  a_q, res_q;
  logic [W-1:0] b_q;
  logic [3:0]   op_q;
  logic [3:0]   cnt_q;
  logic         id_q, perr_q;
  logic [15:0]  out_q;
  logic         oval_q, oid_q, oerr_q;

  logic         gnt0, gnt1, take, pick1;
  logic [W-1:0] sel_a, sel_b;
  logic [3:0]   sel_op;
  logic [15:0]  alu_res;
  logic         alu_err;

`ifdef ALU_ARB_RR_EN
  logic last_q;
  assign pick1 = ~last_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) last_q <= 1'b1;
    else if (take) last_q <= gnt1;
  end
`else
  assign pick1 = 1'b0;
`endif

  // grants are combinational and forced low during reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RST_N && state_q == IDLE) begin
      gnt0 = bus.req0_valid &&
             !(bus.req1_valid && pick1);
      gnt1 = bus.req1_valid &&
             !(bus.req0_valid && !pick1);
    end
  end

  assign take   = gnt0 | gnt1;
  assign sel_a  = gnt1 ? bus.req1_A  : bus.req0_A;
  assign sel_b  = gnt1 ? bus.req1_B  : bus.req0_B;
  assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.out        = out_q;
  assign bus.out_valid  = oval_q;
  assign bus.out_id     = oid_q;
  assign bus.err        = oerr_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take)
              state_d = (sel_op == OP_MUL)
                        ? MUL : ALU;
      ALU:  state_d = RESP;
      MUL:  if (cnt_q == 4'(W - 1))
              state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (1'b1)
      op_q == OP_ADD: alu_res = a_q + 16'(b_q);
      op_q == OP_SUB: alu_res = a_q - 16'(b_q);
      default:        alu_err = 1'b1;
    endcase
  end

  // MUL consumes one multiplier bit per cycle, shifting a_q left
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      id_q   <= 1'b0;
      res_q  <= '0;
      perr_q <= 1'b0;
      cnt_q  <= '0;
    end else if (take) begin
      a_q    <= 16'(sel_a);
      b_q    <= sel_b;
      op_q   <= sel_op;
      id_q   <= gnt1;
      res_q  <= '0;
      perr_q <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == ALU) begin
      res_q  <= alu_res;
      perr_q <= alu_err;
    end else if (state_q == MUL) begin
      if (b_q[0]) res_q <= res_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_q  <= '0;
      oval_q <= 1'b0;
      oid_q  <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      oval_q <= (state_q == RESP);
      if (state_q == RESP) begin
        out_q  <= res_q;
        oid_q  <= id_q;
        oerr_q <= perr_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: random + directed scoreboard bench for alu_arb.
module tb_alu_arb;
  localparam int W = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } op_t;

  typedef struct {
    int out;
    int id;
    int err;
    int due;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  alu_arb_if #(.W(W)) bus();

  alu_arb #(.W(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_until = 0;
  int   last = 1;
  int   last_tr = 0;
  logic g0 = 1'b0;
  logic g1 = 1'b0;
  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   gseq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic int model(int a, int b,
                               logic [3:0] op,
                               output int er);
    er = 0;
    case (op)
      4'b0001: return (a + b) % 65536;
      4'b0010: return (a - b + 65536) % 65536;
      4'b0100: return a * b;
      default: begin er = 1; return 0; end
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int  r;
    o.a = 8'($urandom_range(0, (1 << W) - 1));
    o.b = 8'($urandom_range(0, (1 << W) - 1));
    r = $urandom_range(0, 9);
    if (r < 3) o.op = 4'b0001;
    else if (r < 6) o.op = 4'b0010;
    else if (r < 8) o.op = 4'b0100;
    else begin
      o.op = 4'($urandom_range(0, 15));
      if (o.op inside {4'b0001, 4'b0010, 4'b0100})
        o.op = 4'b1000;
    end
    return o;
  endfunction

  // requester drivers: hold valid until the handshake
  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_A = '0;
    bus.req0_B = '0;
    bus.req0_op = '0;
    forever begin
      @(posedge CLK);
      if (g0) q0.delete(0);
      #1;
      bus.req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin
        bus.req0_A = q0[0].a[W-1:0];
        bus.req0_B = q0[0].b[W-1:0];
        bus.req0_op = q0[0].op;
      end
    end
  end

  initial begin
    bus.req1_valid = 1'b0;
    bus.req1_A = '0;
    bus.req1_B = '0;
    bus.req1_op = '0;
    forever begin
      @(posedge CLK);
      if (g1) q1.delete(0);
      #1;
      bus.req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        bus.req1_A = q1[1 - 1].a[W-1:0];
        bus.req1_B = q1[0].b[W-1:0];
        bus.req1_op = q1[0].op;
      end
    end
  end

  // monitor: grant model, scoreboard push and pop
  int         w, ea, eb, eo, ee, lat;
  logic [3:0] eop;
  exp_t       e;

  always @(negedge CLK) begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out=%0h id=%0d want none",
                 bus.out, bus.out_id);
      end else begin
        e = sb.pop_front();
        chk("out", 32'(bus.out), e.out);
        chk("out_id", 32'(bus.out_id), e.id);
        chk("err", 32'(bus.err), e.err);
        chk("result_cycle", cyc, e.due);
      end
    end
    if (!RST_N) begin
      chk("ready_in_reset",
          32'({bus.req1_ready, bus.req0_ready}), 0);
      sb.delete();
      busy_until = 0;
      last = 1;
    end else begin
      g0 = bus.req0_valid && bus.req0_ready;
      g1 = bus.req1_valid && bus.req1_ready;
      w = -1;
      if (cyc >= busy_until) begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
          w = (last == 1) ? 0 : 1;
`else
          w = 0;
`endif
        end else if (bus.req0_valid) w = 0;
        else if (bus.req1_valid) w = 1;
      end
      chk("ready",
          32'({bus.req1_ready, bus.req0_ready}),
          32'({w == 1, w == 0}));
      if (w >= 0) begin
        ea = (w == 1) ? int'(bus.req1_A) : int'(bus.req0_A);
        eb = (w == 1) ? int'(bus.req1_B) : int'(bus.req0_B);
        eop = (w == 1) ? bus.req1_op : bus.req0_op;
        eo = model(ea, eb, eop, ee);
        lat = (eop == 4'b0100) ? W + 1 : 2;
        sb.push_back('{out: eo, id: w, err: ee,
                       due: cyc + 1 + lat});
        gseq.push_back(w);
        last = w;
        last_tr = cyc + 1;
        busy_until = cyc + 1 + lat;
      end
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic wait_out(string n, output int o,
                          output int id, output int er,
                          output int lt);
    o = -1; id = -1; er = -1; lt = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.out_valid) begin
        o = int'(bus.out);
        id = int'(bus.out_id);
        er = int'(bus.err);
        lt = cyc - last_tr;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: got no out_valid want one within 100 cycles", n);
  endtask

  task automatic wait_idle(string n);
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (q0.size() == 0 && q1.size() == 0 &&
          sb.size() == 0 && cyc >= busy_until)
        return;
    end
    total++;
    bad++;
    $display("FAIL %s: got pending work want drained", n);
  endtask

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  int o, id, er, lt, n;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_id", 32'(bus.out_id), 0);
    chk("rst_err", 32'(bus.err), 0);

    q0.push_back('{8'd9, 8'd7, 4'b0001});
    wait_out("add_wait", o, id, er, lt);
    chk("add_out", o, 16);
    chk("add_id", id, 0);
    chk("add_err", er, 0);
    chk("add_latency", lt, 2);

    q1.push_back('{8'd3, 8'd5, 4'b0010});
    q1.push_back('{8'd15, 8'd15, 4'b0100});
    wait_out("sub_wait", o, id, er, lt);
    chk("sub_out", o, 65534);
    chk("sub_id", id, 1);
    wait_out("mul_wait", o, id, er, lt);
    chk("mul_out", o, 225);
    chk("mul_latency", lt, W + 1);

    q0.push_back('{8'd3, 8'd4, 4'b1000});
    wait_out("ill_wait", o, id, er, lt);
    chk("ill_out", o, 0);
    chk("ill_err", er, 1);
    chk("ill_latency", lt, 2);
    q0.push_back('{8'd1, 8'd2, 4'b0001});
    wait_out("legal_wait", o, id, er, lt);
    chk("legal_err", er, 0);
    chk("legal_out", o, 3);

    do_reset();
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rnd_op());
      q1.push_back(rnd_op());
    end
    wait_idle("tie_drain");
    chk("tie_count", gseq.size(), 8);
    for (int i = 0; i < 8 && i < gseq.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      chk("tie_order", gseq[i], i % 2);
`else
      chk("tie_order", gseq[i], (i < 4) ? 0 : 1);
`endif
    end

    q1.push_back('{8'd13, 8'd11, 4'b0100});
    n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(posedge CLK);
      #2;
      n++;
    end
    chk("mul_abort_start", int'(n < 100), 1);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("abort_out", 32'(bus.out), 0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_out_id", 32'(bus.out_id), 0);
    chk("abort_err", 32'(bus.err), 0);
    repeat (2 * W) @(negedge CLK);
    gseq.delete();
    q0.push_back(rnd_op());
    q1.push_back(rnd_op());
    wait_idle("post_abort_drain");
    chk("post_abort_first", (gseq.size() > 0) ? gseq[0] : -1, 0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel != 1) q0.push_back(rnd_op());
      if (sel != 0) q1.push_back(rnd_op());
      repeat ($urandom_range(0, 6)) @(posedge CLK);
    end
    wait_idle("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
